// File: rtl/mem_stage.sv
// Data-memory stage: word array with byte/half/word loads and stores, combinational
// read data, and a sticky record of the first illegal (misaligned or bad-size) access.
module mem_stage #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic        FaultClear,
  output logic [31:0] ReadData,
  output logic        FaultValid,
  output logic [31:0] FaultAddr,
  output logic        FaultIsStore
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;

  logic [31:0] mem [Words] = '{default: 32'h0};

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  illegal;
  logic                  fault_now;
  logic                  store_en;
  logic [3:0]            byte_en;
  logic [31:0]           wdata;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;

  logic        fault_valid_q;
  logic [31:0] fault_addr_q;
  logic        fault_is_store_q;

  // Upper address bits are dropped, so accesses wrap around the array.
  assign word_idx = Address[DEPTH_LOG2+1:2];

  always_comb begin
    illegal = 1'b1;
    case (MemSize)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = Address[0];
      2'b10:   illegal = |Address[1:0];
      default: illegal = 1'b1;
    endcase
  end

  assign fault_now = (MemRead | MemWrite) & illegal;
  assign store_en  = MemWrite & ~illegal & rst_n;

  // Replicate store data across lanes; byte_en picks which lanes land.
  always_comb begin
    byte_en = 4'b0000;
    wdata   = 32'h0;
    case (MemSize)
      2'b00: begin
        byte_en = 4'b0001 << Address[1:0];
        wdata   = {4{WriteData[7:0]}};
      end
      2'b01: begin
        byte_en = Address[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{WriteData[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b1111;
        wdata   = WriteData;
      end
      default: begin
        byte_en = 4'b0000;
        wdata   = 32'h0;
      end
    endcase
    if (!store_en) begin
      byte_en = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) begin
        mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{Address[1:0], 3'b000} +: 8];
  assign rd_half = rd_word[{Address[1], 4'b0000} +: 16];

  always_comb begin
    ReadData = 32'h0;
    if (MemRead && !illegal) begin
      case (MemSize)
        2'b00:   ReadData = {{24{MemSigned & rd_byte[7]}}, rd_byte};
        2'b01:   ReadData = {{16{MemSigned & rd_half[15]}}, rd_half};
        2'b10:   ReadData = rd_word;
        default: ReadData = 32'h0;
      endcase
    end
  end

  // A new fault beats a simultaneous clear and is captured as the first fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_valid_q    <= 1'b0;
      fault_addr_q     <= 32'h0;
      fault_is_store_q <= 1'b0;
    end else if (fault_now && (!fault_valid_q || FaultClear)) begin
      fault_valid_q    <= 1'b1;
      fault_addr_q     <= Address;
      fault_is_store_q <= MemWrite;
    end else if (FaultClear) begin
      fault_valid_q    <= 1'b0;
    end
  end

  assign FaultValid   = fault_valid_q;
  assign FaultAddr    = fault_addr_q;
  assign FaultIsStore = fault_is_store_q;

endmodule
